// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring unsigned divider sharing one subtract datapath
module div_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH:0] r, r_n, r_sh;
    logic [WIDTH-1:0] q, q_n, d, d_n, quot_n, rem_n;
    logic dbz_n;
    logic [WIDTH+1:0] trial;
    assign o_busy = state == RUN;
    assign o_done = state == DONE;
    always_comb begin
        r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
        // the extra top bit of trial is the adder carry-out: set when no borrow occurred
        trial  = {1'b0, r_sh} + {1'b0, ~{1'b0, d}} + (WIDTH + 2)'(1);
        state_n = state;
        cnt_n   = cnt;
        r_n     = r;
        q_n     = q;
        d_n     = d;
        quot_n  = o_quot;
        rem_n   = o_rem;
        dbz_n   = o_dbz;
        case (state)
            IDLE: if (i_start) begin
                d_n    = i_divisor;
                q_n    = i_dividend;
                r_n    = '0;
                cnt_n  = CW'(WIDTH);
                dbz_n  = i_divisor == '0;
                state_n = dbz_n ? DONE : RUN;
                quot_n = dbz_n ? '1 : o_quot;
                rem_n  = dbz_n ? i_dividend : o_rem;
            end
            RUN: begin
                r_n   = trial[WIDTH+1] ? trial[WIDTH:0] : r_sh;
                q_n   = {q[WIDTH-2:0], trial[WIDTH+1]};
                cnt_n = cnt - CW'(1);
                state_n = cnt == CW'(1) ? DONE : RUN;
                quot_n = cnt == CW'(1) ? q_n : o_quot;
                rem_n  = cnt == CW'(1) ? r_n[WIDTH-1:0] : o_rem;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            o_quot <= '0;
            o_rem  <= '0;
            o_dbz  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            r      <= r_n;
            q      <= q_n;
            d      <= d_n;
            o_quot <= quot_n;
            o_rem  <= rem_n;
            o_dbz  <= dbz_n;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against an arithmetic model
module tb_div_sequencer;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic busy, done, dbz;
    logic [W-1:0] quot, rem;
    int compared = 0, mismatched = 0;
    int m_left = 0;
    bit m_done = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_quot = '0, m_rem = '0, p_q = '0, p_r = '0;
    always #5 clk = ~clk;
    div_sequencer #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dividend(dividend), .i_divisor(divisor),
        .o_busy(busy), .o_done(done), .o_dbz(dbz), .o_quot(quot), .o_rem(rem)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // reference: results come from / and %, timing from a countdown of remaining busy cycles
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_quot = '0; m_rem = '0; m_dbz = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_done = 1; m_quot = p_q; m_rem = p_r; end
        end else if (start) begin
            if (divisor == 0) begin
                m_done = 1; m_quot = '1; m_rem = dividend; m_dbz = 1;
            end else begin
                m_left = W; m_dbz = 0; p_q = dividend / divisor; p_r = dividend % divisor;
            end
        end
        #1;
        chk("cyc_busy", busy, 32'(m_left > 0));
        chk("cyc_done", done, 32'(m_done));
        chk("cyc_dbz", dbz, 32'(m_dbz));
        chk("cyc_quot", quot, 32'(m_quot));
        chk("cyc_rem", rem, 32'(m_rem));
    end
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] dv);
        @(negedge clk); start = 1; dividend = a; divisor = dv;
        @(negedge clk); start = 0; dividend = W'($urandom); divisor = W'($urandom);
    endtask
    task automatic wait_done(input int n0, input int lat, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input bit edbz);
        int n = n0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("done_latency", n, lat);
        chk("quot", quot, 32'(eq));
        chk("rem", rem, 32'(er));
        chk("dbz", dbz, 32'(edbz));
        chk("model_quot", 32'(m_quot), 32'(eq));
        chk("model_rem", 32'(m_rem), 32'(er));
    endtask
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] dv);
        pulse_start(a, dv);
        if (dv == 0) wait_done(1, 1, '1, a, 1);
        else wait_done(1, W + 1, a / dv, a % dv, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_quot", quot, 0);
        rst = 0;
        pulse_start(200, 7);
        chk("nom_busy", busy, 1);
        wait_done(1, 9, 28, 4, 0);
        @(negedge clk);
        chk("hold_done", done, 0); chk("hold_quot", quot, 28); chk("hold_rem", rem, 4);
        pulse_start(255, 1);   wait_done(1, 9, 255, 0, 0);
        pulse_start(5, 9);     wait_done(1, 9, 0, 5, 0);
        pulse_start(255, 255); wait_done(1, 9, 1, 0, 0);
        pulse_start(0, 3);     wait_done(1, 9, 0, 0, 0);
        pulse_start(77, 0);    wait_done(1, 1, 255, 77, 1);
        pulse_start(10, 3);    wait_done(1, 9, 3, 1, 0);
        pulse_start(100, 3);
        repeat (3) @(negedge clk);
        start = 1; dividend = 9; divisor = 9;
        @(negedge clk); start = 0;
        wait_done(5, 9, 33, 1, 0);
        pulse_start(9, 9);     wait_done(1, 9, 1, 0, 0);
        pulse_start(200, 7);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_dbz", dbz, 0);
        chk("mid_rst_quot", quot, 0); chk("mid_rst_rem", rem, 0);
        repeat (12) @(negedge clk);
        pulse_start(50, 6);    wait_done(1, 9, 8, 2, 0);
        for (int i = 0; i < 1000; i++)
            do_op(W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom));
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
